// File: rtl/rib_wb_pkg.sv
// ============================================================================
// Package  : rib_wb_pkg
// Brief    : Shared types, constants and helpers for the RIB-to-Wishbone bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rib_wb_pkg;

    typedef enum logic [0:0] {
        F_IDLE = 1'b0,
        F_BUS  = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_BUS  = 2'd1,
        D_DONE = 2'd2
    } data_state_t;

    // Wide enough for any supported bus; users cast down to their sel width.
    localparam logic [63:0] SEL_ALL = {64{1'b1}};

    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_master_channel.sv
// ============================================================================
// Module   : wb_master_channel
// Brief    : Single classic Wishbone read/write cycle engine with start/done
//            handshake. Optional watchdog under RIB_WB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_channel
    import rib_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      we_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [DATA_WIDTH/8-1:0]   sel_o,
    output logic [ADDR_WIDTH-1:0]     addr_o,
    output logic [DATA_WIDTH-1:0]     data_o,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic                      ack_i
);

    localparam int                    SEL_W      = DATA_WIDTH / 8;
    localparam logic [SEL_W-1:0]      SEL_MASK   = SEL_W'(SEL_ALL);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(word_align({64{1'b1}}));

    logic                  cyc_q;
    logic                  we_q;
    logic [SEL_W-1:0]      sel_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else if (!cyc_q) begin
            if (start_i) begin
                cyc_q  <= 1'b1;
                we_q   <= we_i;
                sel_q  <= SEL_MASK;
                addr_q <= addr_i & ALIGN_MASK;
                data_q <= wdata_i;
            end
        end else if (done_o) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= '0;
        end
    end

`ifdef RIB_WB_TIMEOUT_EN
    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Counts bus cycles spent waiting; saturates so a held abort stays stable.
    always_ff @(posedge clk) begin
        if (rst || !cyc_q) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign w_timeout = cyc_q & ~ack_i & (cnt_q == CNT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // An aborted cycle returns zero data; ack always wins over the watchdog.
    assign done_o    = cyc_q & (ack_i | w_timeout);
    assign timeout_o = w_timeout;
    assign rdata_o   = ack_i ? data_i : '0;

    assign cyc_o  = cyc_q;
    assign stb_o  = cyc_q;
    assign we_o   = we_q;
    assign sel_o  = sel_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/rib_wb_bridge.sv
// ============================================================================
// Module   : rib_wb_bridge
// Brief    : RIB core interface to two classic Wishbone masters (fetch, data).
// Options  : RIB_WB_TIMEOUT_EN enables per-channel watchdogs and sticky err_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rib_wb_bridge
    import rib_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   rib_pc_addr_i,
    output logic [DATA_WIDTH-1:0]   rib_pc_data_o,
    input  logic [ADDR_WIDTH-1:0]   rib_ex_addr_i,
    input  logic [DATA_WIDTH-1:0]   rib_ex_data_i,
    output logic [DATA_WIDTH-1:0]   rib_ex_data_o,
    input  logic                    rib_ex_req_i,
    input  logic                    rib_ex_we_i,
    output logic                    hold_o,
    output logic                    i_cyc_o,
    output logic                    i_stb_o,
    output logic                    i_we_o,
    output logic [DATA_WIDTH/8-1:0] i_sel_o,
    output logic [ADDR_WIDTH-1:0]   i_addr_o,
    output logic [DATA_WIDTH-1:0]   i_data_o,
    input  logic [DATA_WIDTH-1:0]   i_data_i,
    input  logic                    i_ack_i,
    output logic                    d_cyc_o,
    output logic                    d_stb_o,
    output logic                    d_we_o,
    output logic [DATA_WIDTH/8-1:0] d_sel_o,
    output logic [ADDR_WIDTH-1:0]   d_addr_o,
    output logic [DATA_WIDTH-1:0]   d_data_o,
    input  logic [DATA_WIDTH-1:0]   d_data_i,
    input  logic                    d_ack_i,
    output logic                    err_o
);

    fetch_state_t          f_state_q, f_state_d;
    data_state_t           d_state_q, d_state_d;

    logic [ADDR_WIDTH-1:0] tag_q;
    logic                  tag_valid_q;
    logic [ADDR_WIDTH-1:0] pend_q;
    logic [DATA_WIDTH-1:0] pc_data_q;
    logic [DATA_WIDTH-1:0] ex_data_q;

    logic                  w_f_miss;
    logic                  w_f_start;
    logic                  w_f_done;
    logic                  w_f_timeout;
    logic [DATA_WIDTH-1:0] w_f_rdata;
    logic                  w_d_start;
    logic                  w_d_done;
    logic                  w_d_timeout;
    logic [DATA_WIDTH-1:0] w_d_rdata;

    // Full-address compare: any change of pc, even within a word, refetches.
    assign w_f_miss = !tag_valid_q || (rib_pc_addr_i != tag_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            f_state_q <= F_IDLE;
            d_state_q <= D_IDLE;
        end else begin
            f_state_q <= f_state_d;
            d_state_q <= d_state_d;
        end
    end

    always_comb begin
        f_state_d = f_state_q;
        case (f_state_q)
            F_IDLE:  if (w_f_miss) f_state_d = F_BUS;
            F_BUS:   if (w_f_done) f_state_d = F_IDLE;
            default: f_state_d = F_IDLE;
        endcase

        d_state_d = d_state_q;
        case (d_state_q)
            D_IDLE:  if (rib_ex_req_i) d_state_d = D_BUS;
            D_BUS:   if (w_d_done) d_state_d = D_DONE;
            D_DONE:  d_state_d = D_IDLE;
            default: d_state_d = D_IDLE;
        endcase
    end

    always_comb begin
        w_f_start = (f_state_q == F_IDLE) && w_f_miss;
        w_d_start = (d_state_q == D_IDLE) && rib_ex_req_i;
        hold_o    = w_f_start || (f_state_q == F_BUS) ||
                    (d_state_q == D_BUS) || w_d_start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            pend_q      <= '0;
            pc_data_q   <= '0;
            ex_data_q   <= '0;
        end else begin
            if (w_f_start) begin
                pend_q <= rib_pc_addr_i;
            end
            if ((f_state_q == F_BUS) && w_f_done) begin
                pc_data_q   <= w_f_rdata;
                tag_q       <= pend_q;
                tag_valid_q <= 1'b1;
            end
            if ((d_state_q == D_BUS) && w_d_done && !d_we_o) begin
                ex_data_q <= w_d_rdata;
            end
        end
    end

    assign rib_pc_data_o = pc_data_q;
    assign rib_ex_data_o = ex_data_q;

    wb_master_channel #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fetch_ch (
        .clk       (clk),
        .rst       (rst),
        .start_i   (w_f_start),
        .we_i      (1'b0),
        .addr_i    (rib_pc_addr_i),
        .wdata_i   ({DATA_WIDTH{1'b0}}),
        .done_o    (w_f_done),
        .timeout_o (w_f_timeout),
        .rdata_o   (w_f_rdata),
        .cyc_o     (i_cyc_o),
        .stb_o     (i_stb_o),
        .we_o      (i_we_o),
        .sel_o     (i_sel_o),
        .addr_o    (i_addr_o),
        .data_o    (i_data_o),
        .data_i    (i_data_i),
        .ack_i     (i_ack_i)
    );

    wb_master_channel #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_data_ch (
        .clk       (clk),
        .rst       (rst),
        .start_i   (w_d_start),
        .we_i      (rib_ex_we_i),
        .addr_i    (rib_ex_addr_i),
        .wdata_i   (rib_ex_data_i),
        .done_o    (w_d_done),
        .timeout_o (w_d_timeout),
        .rdata_o   (w_d_rdata),
        .cyc_o     (d_cyc_o),
        .stb_o     (d_stb_o),
        .we_o      (d_we_o),
        .sel_o     (d_sel_o),
        .addr_o    (d_addr_o),
        .data_o    (d_data_o),
        .data_i    (d_data_i),
        .ack_i     (d_ack_i)
    );

`ifdef RIB_WB_TIMEOUT_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (w_f_timeout || w_d_timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    // Both timeout strobes are tied low inside the channels in this build.
    assign err_o = w_f_timeout | w_d_timeout;
`endif

endmodule

`default_nettype wire
